// File: rtl/udp_md_pkg.sv
// ---------------------------------------------------------------------------
// udp_md_pkg
//   Shared definitions for the UDP market-data parser: default payload
//   offset, field positions inside the UDP payload, field width and the
//   32-bit symbol / price types.
// ---------------------------------------------------------------------------
package udp_md_pkg;

    // 14 B Ethernet + 20 B IPv4 + 8 B UDP headers precede the payload.
    localparam int DEFAULT_PAYLOAD_OFFSET = 42;

    // Field positions relative to the first payload byte.
    localparam int SYMBOL_OFFSET = 0;
    localparam int PRICE_OFFSET  = 4;

    // Both fields are four bytes wide, transmitted MSB first.
    localparam int FIELD_BYTES = 4;

    typedef logic [8*FIELD_BYTES-1:0] symbol_t;  // ASCII, first char in [31:24]
    typedef logic [8*FIELD_BYTES-1:0] price_t;   // big-endian unsigned price

endpackage

// File: rtl/udp_md_parser.sv
// ---------------------------------------------------------------------------
// udp_md_parser
//   Byte-serial market-data parser. Counts the bytes of a raw
//   Ethernet/IPv4/UDP frame arriving on an 8-bit AXI-Stream (no
//   backpressure), captures a 4-byte symbol and 4-byte price at fixed
//   payload offsets and strobes the price out when the symbol matches the
//   programmed target.
//
// Ports
//   clk            single rising-edge clock
//   rst            asynchronous active-high reset
//   s_axis_tdata   stream byte
//   s_axis_tvalid  beat valid; every valid beat is accepted
//   s_axis_tlast   last byte of the frame (qualified by tvalid)
//   target_symbol  symbol to match; held stable while a frame is in flight
//   price_data     last matched price
//   price_valid    one-cycle strobe: price_data was just updated
// ---------------------------------------------------------------------------
module udp_md_parser
    import udp_md_pkg::*;
#(
    parameter int PAYLOAD_OFFSET = DEFAULT_PAYLOAD_OFFSET,
    parameter int COUNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic [31:0] target_symbol,
    output logic [31:0] price_data,
    output logic        price_valid
);

    // Absolute byte indices of the two fields within the frame.
    localparam logic [COUNT_W-1:0] SYM_FIRST   = COUNT_W'(PAYLOAD_OFFSET + SYMBOL_OFFSET);
    localparam logic [COUNT_W-1:0] SYM_LAST    = COUNT_W'(PAYLOAD_OFFSET + SYMBOL_OFFSET + FIELD_BYTES - 1);
    localparam logic [COUNT_W-1:0] PRICE_FIRST = COUNT_W'(PAYLOAD_OFFSET + PRICE_OFFSET);
    localparam logic [COUNT_W-1:0] PRICE_LAST  = COUNT_W'(PAYLOAD_OFFSET + PRICE_OFFSET + FIELD_BYTES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

    logic [COUNT_W-1:0] cnt;       // index of the next accepted byte
    symbol_t            sym;       // symbol shift register
    price_t             price_sh;  // leading price bytes

    // Window decodes on the index of the byte being accepted this cycle.
    logic in_sym_window;
    logic in_price_window;
    logic at_price_last;

    assign in_sym_window   = (cnt >= SYM_FIRST)   && (cnt <= SYM_LAST);
    assign in_price_window = (cnt >= PRICE_FIRST) && (cnt <  PRICE_LAST);
    assign at_price_last   = (cnt == PRICE_LAST);

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            sym         <= '0;
            price_sh    <= '0;
            price_data  <= '0;
            price_valid <= 1'b0;
        end else begin
            // Strobe defaults low; it is raised only on the completing byte.
            price_valid <= 1'b0;

            if (s_axis_tvalid) begin
                // Saturate so an oversize frame can never wrap back into the
                // payload window and fire a second time.
                if (s_axis_tlast) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + COUNT_W'(1);
                end

                // A frame that ends early leaves partial bytes behind; they
                // are harmless because the next frame shifts in a full field
                // before the compare is ever evaluated.
                if (in_sym_window) begin
                    sym <= {sym[23:0], s_axis_tdata};
                end

                if (in_price_window) begin
                    price_sh <= {price_sh[23:0], s_axis_tdata};
                end

                if (at_price_last && (sym == target_symbol)) begin
                    price_data  <= {price_sh[23:0], s_axis_tdata};
                    price_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_md_parser.sv
module tb_udp_md_parser;
    import udp_md_pkg::*;

    localparam symbol_t SYM_0050 = 32'h30303530;  // "0050"
    localparam symbol_t SYM_2330 = 32'h32333330;  // "2330"

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic [31:0] target_symbol;
    logic [31:0] price_data;
    logic        price_valid;

    udp_md_parser #(.PAYLOAD_OFFSET(42), .COUNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .target_symbol(target_symbol),
        .price_data   (price_data),
        .price_valid  (price_valid)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     pulses;
    logic   prev_pv = 1'b0;
    price_t model_price = '0;
    logic [7:0] fb [0:127];

    typedef struct {
        symbol_t target;
        symbol_t sym;
        price_t  price;
        int      len;
        int      gap_pct;
        int      exp_pulses;
        price_t  exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 time unit later.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        @(posedge clk);
        #1;
        if (price_valid) begin
            pulses++;
            check("single_cycle_strobe", {31'b0, prev_pv}, 32'd0);
        end
        prev_pv = price_valid;
        s_axis_tvalid = 1'b0;
    endtask

    // Header bytes are their own index; symbol and price at payload offsets.
    task automatic build_frame(input symbol_t sym, input price_t price);
        for (int i = 0; i < 128; i++) fb[i] = i[7:0];
        for (int b = 0; b < 4; b++) begin
            fb[42 + b] = sym[31 - 8*b -: 8];
            fb[46 + b] = price[31 - 8*b -: 8];
        end
    endtask

    // Frames longer than the buffer repeat it every 65536 bytes, so a
    // wrapping counter would meet the symbol/price a second time.
    function automatic logic [7:0] get_byte(input int i);
        int k;
        k = i % 65536;
        return (k < 128) ? fb[k] : i[7:0];
    endfunction

    task automatic send_frame(input string name, input symbol_t target, input int len,
                              input int gap_pct, input int exp_pulses, input price_t exp_data);
        target_symbol = target;
        pulses = 0;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < 3 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++)
                cycle(1'b0, 8'($urandom), 1'($urandom));
            cycle(1'b1, get_byte(i), i == len - 1);
            if (i == 49) begin
                check($sformatf("%s strobe_at_49", name), {31'b0, price_valid},
                      (exp_pulses > 0) ? 32'd1 : 32'd0);
                if (exp_pulses > 0)
                    check($sformatf("%s data_at_49", name), price_data, exp_data);
            end
        end
        check($sformatf("%s pulse_count", name), pulses, exp_pulses);
        check($sformatf("%s price_data", name), price_data, exp_data);
        model_price = exp_data;
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        target_symbol = SYM_0050;

        // Expected results below are worked out by hand from the frame rules.
        vecs[0] = '{SYM_0050, SYM_0050, 32'd15000,    50,  0, 1, 32'd15000};
        vecs[1] = '{SYM_2330, SYM_0050, 32'd2048,     50,  0, 0, 32'd15000};
        vecs[2] = '{SYM_0050, SYM_0050, 32'd777,      48,  0, 0, 32'd15000};
        vecs[3] = '{SYM_0050, SYM_0050, 32'd15000,    50,  0, 1, 32'd15000};
        vecs[4] = '{SYM_0050, SYM_0050, 32'h12345678, 64,  0, 1, 32'h12345678};
        vecs[5] = '{SYM_0050, SYM_0050, 32'hDEADBEEF, 50, 40, 1, 32'hDEADBEEF};
        vecs[6] = '{SYM_0050, SYM_2330, 32'h00000001, 55, 20, 0, 32'hDEADBEEF};

        repeat (2) @(posedge clk);
        #1;
        check("reset price_valid", {31'b0, price_valid}, 32'd0);
        check("reset price_data", price_data, 32'd0);
        rst = 1'b0;

        // Table vectors, sent back to back with no idle between frames.
        for (int k = 0; k < 7; k++) begin
            build_frame(vecs[k].sym, vecs[k].price);
            send_frame($sformatf("vec%0d", k), vecs[k].target, vecs[k].len,
                       vecs[k].gap_pct, vecs[k].exp_pulses, vecs[k].exp_data);
        end

        // Reset asserted while byte 45 of a matching frame is on the bus.
        build_frame(SYM_0050, 32'hCAFEF00D);
        target_symbol = SYM_0050;
        for (int i = 0; i < 45; i++) cycle(1'b1, get_byte(i), 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = fb[45];
        s_axis_tlast  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midreset price_valid", {31'b0, price_valid}, 32'd0);
        check("midreset price_data", price_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        prev_pv = 1'b0;
        check("after_reset price_data", price_data, 32'd0);
        send_frame("post_reset", SYM_0050, 50, 0, 1, 32'hCAFEF00D);

        // Randomized frames against the frame-level reference rule.
        for (int r = 0; r < 24; r++) begin
            symbol_t tgt, sym;
            price_t  pr;
            int      len, gap, exp_n;
            price_t  exp_d;
            tgt = ($urandom_range(1) == 1) ? SYM_0050 : $urandom;
            sym = ($urandom_range(2) != 0) ? tgt : $urandom;
            pr  = $urandom;
            len = $urandom_range(40, 70);
            gap = ($urandom_range(1) == 1) ? 25 : 0;
            build_frame(sym, pr);
            // A frame produces a price iff it reaches the last price byte and
            // the four symbol bytes equal the target.
            exp_n = (len >= 50 && {fb[42], fb[43], fb[44], fb[45]} == tgt) ? 1 : 0;
            exp_d = (exp_n == 1) ? {fb[46], fb[47], fb[48], fb[49]} : model_price;
            send_frame($sformatf("rand%0d", r), tgt, len, gap, exp_n, exp_d);
        end

        // Oversize frame: the counter must saturate, never re-enter the window.
        build_frame(SYM_0050, 32'h0BADCAFE);
        send_frame("oversize", SYM_0050, 65536 + 50, 0, 1, 32'h0BADCAFE);

        // Next frame after the oversize one starts again at index 0.
        build_frame(SYM_0050, 32'h00ABCDEF);
        send_frame("after_oversize", SYM_0050, 50, 0, 1, 32'h00ABCDEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
